// File: rtl/rv32_run_control_pkg.sv
// rv32_run_control_pkg: shared types for the run/step controller.
// Controller states, halt causes and the EBREAK encoding.
package rv32_run_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_HOLD,
    ST_RUN,
    ST_PAUSE,
    ST_STEP,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    HALT_NONE   = 2'd0,
    HALT_EBREAK = 2'd1,
    HALT_STALL  = 2'd2,
    HALT_LIMIT  = 2'd3
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INSTRUCTION = 32'h0010_0073;

  function automatic logic is_ebreak(input logic [31:0] insn);
    return insn == EBREAK_INSTRUCTION;
  endfunction

endpackage

// File: rtl/rv32_pc_stall_detector.sv
// rv32_pc_stall_detector: flags a pc that has not moved
// for STALL_LIMIT consecutive sampled cycles.
module rv32_pc_stall_detector #(
  parameter int PC_WIDTH    = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                sample,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                stall
);

  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(STALL_LIMIT);
  localparam logic [RW-1:0] RUN_LAST = RW'(STALL_LIMIT - 1);

  logic [PC_WIDTH-1:0] last_pc;
  logic                have_last;
  logic [RW-1:0]       run_len;
  logic                same;

  // Run length includes the current cycle; pulse once when it hits the limit.
  always_comb begin
    same  = have_last && (pc == last_pc);
    stall = sample && same && (run_len == RUN_LAST);
  end

  // Track the previous sampled pc and how long it has been repeated.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      last_pc   <= '0;
      have_last <= 1'b0;
      run_len   <= '0;
    end else if (sample) begin
      last_pc   <= pc;
      have_last <= 1'b1;
      if (!same)
        run_len <= RW'(1);
      else if (run_len != RUN_MAX)
        run_len <= run_len + RW'(1);
    end
  end

endmodule

// File: rtl/rv32_run_control.sv
// rv32_run_control: reset sequencing, run/step gating, cycle
// counting and halt detection for the single-cycle RV32 core.
module rv32_run_control #(
  parameter int PC_WIDTH          = 32,
  parameter int COUNT_WIDTH       = 32,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int STALL_LIMIT       = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   mode_step,
  input  logic                   step,
  input  logic [COUNT_WIDTH-1:0] cycle_limit,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [31:0]            instruction,
  output logic                   core_reset_n,
  output logic                   enable,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] instret_count,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic                   done
);

  import rv32_run_control_pkg::*;

  localparam int HOLD = (RESET_HOLD_CYCLES < 1) ? 1 : RESET_HOLD_CYCLES;
  localparam int HW   = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD);

  state_t                 state;
  logic [HW-1:0]          hold_cnt;
  logic                   stall;
  logic                   clear_stall;
  logic [COUNT_WIDTH-1:0] cycle_inc;
  logic [COUNT_WIDTH-1:0] instret_inc;
  logic                   hit_ebreak;
  logic                   hit_limit;
  logic                   halt_now;
  halt_cause_t            cause_now;

  assign clear_stall = start &&
    (state == ST_IDLE || state == ST_HALTED);

  rv32_pc_stall_detector #(
    .PC_WIDTH    (PC_WIDTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear_stall),
    .sample  (enable),
    .pc      (pc),
    .stall   (stall)
  );

  // Saturating counter increments and prioritised halt detection.
  always_comb begin
    cycle_inc = (&cycle_count) ? cycle_count
              : cycle_count + COUNT_WIDTH'(1);
    instret_inc = (&instret_count) ? instret_count
                : instret_count + COUNT_WIDTH'(1);
    hit_ebreak = is_ebreak(instruction);
    hit_limit  = (cycle_limit != '0) &&
                 (cycle_inc == cycle_limit);
    halt_now   = enable && (hit_ebreak || stall || hit_limit);
    cause_now  = HALT_NONE;
    if (hit_ebreak)
      cause_now = HALT_EBREAK;
    else if (stall)
      cause_now = HALT_STALL;
    else if (hit_limit)
      cause_now = HALT_LIMIT;
  end

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      core_reset_n  <= 1'b0;
      enable        <= 1'b0;
      cycle_count   <= '0;
      instret_count <= '0;
      halted        <= 1'b0;
      halt_cause    <= HALT_NONE;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (enable) begin
        cycle_count   <= cycle_inc;
        instret_count <= instret_inc;
      end
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state         <= ST_RESET_HOLD;
            hold_cnt      <= HOLD_LOAD;
            core_reset_n  <= 1'b0;
            enable        <= 1'b0;
            halted        <= 1'b0;
            halt_cause    <= HALT_NONE;
            cycle_count   <= '0;
            instret_count <= '0;
          end
        end
        ST_RESET_HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
            if (hold_cnt == HW'(1))
              core_reset_n <= 1'b1;
          end else if (mode_step) begin
            state <= ST_PAUSE;
          end else begin
            state  <= ST_RUN;
            enable <= 1'b1;
          end
        end
        ST_RUN, ST_STEP: begin
          if (halt_now) begin
            state      <= ST_HALTED;
            enable     <= 1'b0;
            halted     <= 1'b1;
            halt_cause <= cause_now;
            done       <= 1'b1;
          end else if (state == ST_STEP || mode_step) begin
            state  <= ST_PAUSE;
            enable <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (step) begin
            state  <= ST_STEP;
            enable <= 1'b1;
          end else if (!mode_step) begin
            state  <= ST_RUN;
            enable <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_run_control.sv
// tb_rv32_run_control: scoreboard bench for the run controller;
// per-run programs are replayed one entry per enabled cycle.
module tb_rv32_run_control;

  localparam int HOLD  = 4;
  localparam int STALL = 8;
  localparam int MAXP  = 100;
  localparam logic [31:0] EB  = 32'h0010_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] count;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode_step;
  logic        step;
  logic [31:0] cycle_limit;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        core_reset_n;
  logic        enable;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
  logic        halted;
  logic [1:0]  halt_cause;
  logic        done;

  int checks = 0;
  int errors = 0;
  int idx    = 1;
  int en_cnt = 0;
  logic [31:0] prog_pc  [1:MAXP];
  logic [31:0] prog_ins [1:MAXP];
  exp_t sbq[$];

  rv32_run_control #(
    .PC_WIDTH          (32),
    .COUNT_WIDTH       (32),
    .RESET_HOLD_CYCLES (HOLD),
    .STALL_LIMIT       (STALL)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .mode_step     (mode_step),
    .step          (step),
    .cycle_limit   (cycle_limit),
    .pc            (pc),
    .instruction   (instruction),
    .core_reset_n  (core_reset_n),
    .enable        (enable),
    .cycle_count   (cycle_count),
    .instret_count (instret_count),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .done          (done)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the program and find the first enabled cycle that halts.
  function automatic exp_t model(input logic [31:0] lim);
    exp_t r;
    int run;
    r.cause = 0;
    r.count = 0;
    run = 0;
    for (int k = 1; k <= MAXP; k++) begin
      if (k > 1 && prog_pc[k] == prog_pc[k-1])
        run++;
      else
        run = 1;
      if (prog_ins[k] == EB)
        r.cause = 1;
      else if (run >= STALL)
        r.cause = 2;
      else if (lim != 0 && 32'(k) == lim)
        r.cause = 3;
      if (r.cause != 0) begin
        r.count = 32'(k);
        return r;
      end
    end
    return r;
  endfunction

  // Program replay: one entry presented per enabled cycle.
  initial forever begin
    @(negedge clock);
    if (enable === 1'b1) begin
      if (idx <= MAXP) begin
        pc          = prog_pc[idx];
        instruction = prog_ins[idx];
      end
      idx++;
      en_cnt++;
    end
  end

  // Monitor: every done pulse is matched against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: cause %0d count %0d, none queued",
                 halt_cause, cycle_count);
      end else begin
        e = sbq.pop_front();
        check("halt_cause", 32'(halt_cause), e.cause);
        check("halt_count", cycle_count, e.count);
        check("halt_instret", instret_count, e.count);
        check("halted_flag", 32'(halted), 32'd1);
        check("enable_after_halt", 32'(enable), 32'd0);
      end
    end
  end

  task automatic prog_linear();
    for (int k = 1; k <= MAXP; k++) begin
      prog_pc[k]  = 32'h1000 + 32'(4 * k);
      prog_ins[k] = NOP;
    end
    prog_ins[MAXP] = EB;
  endtask

  task automatic gen_random(output logic [31:0] lim);
    int s;
    int len;
    int eb;
    for (int k = 1; k <= MAXP; k++) begin
      prog_pc[k]  = 32'h2000 + 32'(4 * k);
      prog_ins[k] = $urandom;
      if (prog_ins[k] == EB)
        prog_ins[k] = NOP;
    end
    if ($urandom_range(0, 1) == 1) begin
      s   = $urandom_range(2, 70);
      len = $urandom_range(2, 12);
      for (int k = s; k < s + len && k <= MAXP; k++)
        prog_pc[k] = prog_pc[s];
    end
    if ($urandom_range(0, 2) == 0) begin
      eb = $urandom_range(1, 90);
      prog_ins[eb] = EB;
    end
    if ($urandom_range(0, 1) == 1)
      lim = 32'($urandom_range(1, 90));
    else
      lim = 32'd0;
    prog_ins[MAXP] = EB;
  endtask

  task automatic pulse_start(input bit free);
    int lows;
    idx    = 1;
    en_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_clears_count", cycle_count, 32'd0);
    check("start_clears_cause", 32'(halt_cause), 32'd0);
    check("start_clears_halted", 32'(halted), 32'd0);
    lows = 0;
    while (core_reset_n === 1'b0 && lows < 20) begin
      lows++;
      @(negedge clock);
    end
    check("reset_hold_len", 32'(lows), 32'(HOLD));
    check("enable_at_release", 32'(enable), 32'd0);
    @(negedge clock);
    check("first_enable", 32'(enable), 32'(free));
    if (free) begin
      @(negedge clock);
      check("count_after_first", cycle_count, 32'd1);
    end
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: halted %b after %0d cycles, want 1",
               name, halted, n);
      sbq.delete();
    end else begin
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic run_directed(input string name,
                              input logic [31:0] lim,
                              input logic [31:0] cause,
                              input logic [31:0] count);
    exp_t e;
    e.cause = cause;
    e.count = count;
    cycle_limit = lim;
    sbq.push_back(e);
    pulse_start(1'b1);
    wait_halt(name);
  endtask

  initial begin
    logic [31:0] lim;
    reset_n     = 1'b0;
    start       = 1'b0;
    mode_step   = 1'b0;
    step        = 1'b0;
    cycle_limit = '0;
    pc          = '0;
    instruction = '0;
    repeat (3) @(negedge clock);
    check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_instret", instret_count, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    prog_linear();
    prog_ins[10] = EB;
    run_directed("ebreak", 32'd0, 32'd1, 32'd10);

    prog_linear();
    for (int k = 5; k <= MAXP; k++)
      prog_pc[k] = 32'h0000_0040;
    prog_ins[MAXP] = NOP;
    run_directed("stall", 32'd0, 32'd2, 32'd12);

    prog_linear();
    run_directed("limit", 32'd20, 32'd3, 32'd20);

    prog_linear();
    prog_ins[20] = EB;
    run_directed("ebreak_over_limit", 32'd20, 32'd1, 32'd20);

    prog_linear();
    prog_ins[10] = EB;
    cycle_limit = '0;
    mode_step = 1'b1;
    pulse_start(1'b0);
    repeat (3) @(negedge clock);
    check("pause_enable", 32'(enable), 32'd0);
    en_cnt = 0;
    step = 1'b1;
    @(negedge clock);
    @(negedge clock);
    step = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      repeat (4) @(negedge clock);
    end
    check("step_enable_cycles", 32'(en_cnt), 32'd3);
    check("step_cycle_count", cycle_count, 32'd3);
    check("step_instret", instret_count, 32'd3);
    check("step_not_halted", 32'(halted), 32'd0);
    sbq.push_back('{cause: 32'd1, count: 32'd10});
    mode_step = 1'b0;
    wait_halt("step_resume");

    for (int r = 0; r < 25; r++) begin
      gen_random(lim);
      cycle_limit = lim;
      sbq.push_back(model(lim));
      pulse_start(1'b1);
      wait_halt("random");
    end

    prog_linear();
    cycle_limit = '0;
    pulse_start(1'b1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_enable", 32'(enable), 32'd0);
    check("midrst_core_reset_n", 32'(core_reset_n), 32'd0);
    check("midrst_cycle_count", cycle_count, 32'd0);
    check("midrst_instret", instret_count, 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    prog_linear();
    run_directed("after_reset", 32'd7, 32'd3, 32'd7);

    repeat (3) @(negedge clock);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0",
               sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_run_control.md
Name: rv32_run_control

Overview:
- Synthesizable run/step controller for the single-cycle RV32 core. Replaces the free-running clock/enable stimulus.
- Sequences the core's reset and gates its enable. Supports free-run and single-step modes.
- Counts executed cycles and detects program end by EBREAK, a PC self-loop or a cycle limit, then reports a halt cause.
- Sits between bench or top level and the core's enable and reset inputs.

Parameters:
- PC_WIDTH, 32, width of the pc input.
- COUNT_WIDTH, 32, width of cycle_count, instret_count and cycle_limit.
- RESET_HOLD_CYCLES, 4, cycles core_reset_n is held low after start. 0 is treated as 1.
- STALL_LIMIT, 8, consecutive enabled cycles with unchanged pc that declare a self-loop halt. Must be ≥2.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  level-sampled; begins (or restarts) a run from IDLE or HALTED.
- mode_step  input  1  1 = single-step mode, 0 = free run.
- step  input  1  one-cycle pulse; in PAUSE, grants exactly one enabled cycle.
- cycle_limit  input  COUNT_WIDTH  halt when cycle_count reaches this value. 0 = unlimited.
- pc  input  PC_WIDTH  core program counter.
- instruction  input  32  instruction the core is executing this cycle.
- core_reset_n  output  1  registered; active-low reset to the core and register file.
- enable  output  1  registered; core advances one instruction in each cycle it is high.
- cycle_count  output  COUNT_WIDTH  enabled cycles since start. Saturates at all-ones.
- instret_count  output  COUNT_WIDTH  retired instructions. Equals enabled cycles, minus none (single-cycle core).
- halted  output  1  high while in HALTED.
- halt_cause  output  2  0 NONE, 1 EBREAK, 2 STALL, 3 LIMIT. Held until the next start.
- done  output  1  one-cycle pulse on entry to HALTED.

Behaviour:
- reset_n low at a clock edge → state IDLE and all outputs 0, including core_reset_n = 0 and both counters = 0. This applies mid-run, with no residual enable cycle.
- States: IDLE, RESET_HOLD, RUN, PAUSE, STEP, HALTED.
- IDLE:
  - core_reset_n = 0, enable = 0.
  - start = 1 → RESET_HOLD. Clear counters, halt_cause and the stall counter; load the hold counter.
- RESET_HOLD:
  - core_reset_n stays low for exactly RESET_HOLD_CYCLES cycles.
  - On expiry, core_reset_n = 1 and the state moves to RUN if mode_step = 0, else PAUSE.
  - First enable high is the cycle after core_reset_n rises.
- RUN:
  - enable = 1.
  - mode_step = 1 → PAUSE; enable drops the next cycle.
  - start is ignored.
- PAUSE:
  - enable = 0.
  - step = 1 → STEP.
  - mode_step = 0 → RUN.
  - If step and a mode_step fall arrive together, step wins.
- STEP: enable = 1 for exactly one cycle, then PAUSE, unless a halt condition fires. A step pulse received during STEP is dropped.
- Every cycle with enable = 1:
  - cycle_count and instret_count increment, saturating.
  - Halt checks are evaluated on that cycle's pc and instruction:
    - EBREAK: instruction == 32'h0010_0073.
    - STALL: pc equal to the previous enabled cycle's pc for STALL_LIMIT consecutive enabled cycles. The stall counter resets on any pc change; paused cycles neither advance nor reset it.
    - LIMIT: cycle_limit ≠ 0 and the post-increment cycle_count == cycle_limit.
  - Priority EBREAK > STALL > LIMIT. The halting cycle itself is counted.
- Halt → HALTED on the next edge:
  - enable = 0 from that edge.
  - core_reset_n stays 1, so core state remains inspectable.
  - halted = 1, halt_cause latched, done = 1 for one cycle.
- HALTED: start = 1 → RESET_HOLD, a full restart with counters cleared.
- cycle_limit and mode_step may change at any time; they take effect at the next evaluation.

Decomposition:
- Package rv32_run_control_pkg:
  - state enum;
  - halt_cause enum (NONE/EBREAK/STALL/LIMIT);
  - localparam EBREAK_INSTRUCTION = 32'h0010_0073.
- Sub-module rv32_pc_stall_detector, parameters PC_WIDTH and STALL_LIMIT:
  - inputs clock, reset_n, clear, sample (= enable), pc;
  - output stall, a one-cycle pulse.

Test Plan:
- Reset/start: reset_n low 3 cycles, then start=1, mode_step=0 → core_reset_n low exactly 4 cycles; enable rises the cycle after core_reset_n rises; cycle_count = 1 after the first enabled cycle.
- EBREAK: cycle_limit=0; instruction=32'h0010_0073 on the 10th enabled cycle → halt_cause=1, cycle_count=10, done pulses once, enable low the next cycle.
- Self-loop: pc held at 32'h0000_0040 from enabled cycle 5 onward → halt on cycle 12 (STALL_LIMIT=8 equal-pc cycles counted from cycle 5), halt_cause=2.
- Limit and priority: cycle_limit=20 → halt_cause=3 with cycle_count=20. Separately, cycle_limit=20 with EBREAK on cycle 20 → halt_cause=1.
- Step mode: mode_step=1, three step pulses spaced 5 cycles apart → exactly 3 enable-high cycles, cycle_count=3; a second step inside STEP is dropped.
- Mid-run reset and restart: reset_n low during RUN → enable=0 and core_reset_n=0 the next cycle, counters 0. Start again from HALTED → counters cleared and halt_cause=0.
